// File: rtl/dfr_pkg.sv
// ============================================================================
//  Module      : dfr_pkg
//  Description : Shared types, constants and the phase-selection helper for
//                the DFR phase sequencer.
//  Contents    : CNT_W, phase_t, seq_state_t and next_phase().
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dfr_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_INIT  = 2'd1,
    PH_TRAIN = 2'd2,
    PH_TEST  = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEL_PHASE = 3'd1,
    FETCH     = 3'd2,
    STEP      = 3'd3,
    DONE      = 3'd4
  } seq_state_t;

  // First phase strictly after cur (INIT -> TRAIN -> TEST) whose count is
  // nonzero. PH_IDLE as the result means no phase remains.
  function automatic phase_t next_phase(input phase_t cur,
                                        input logic   init_nz,
                                        input logic   train_nz,
                                        input logic   test_nz);
    phase_t nxt;
    nxt = PH_IDLE;
    case (cur)
      PH_IDLE: begin
        if (init_nz)       nxt = PH_INIT;
        else if (train_nz) nxt = PH_TRAIN;
        else if (test_nz)  nxt = PH_TEST;
      end
      PH_INIT: begin
        if (train_nz)      nxt = PH_TRAIN;
        else if (test_nz)  nxt = PH_TEST;
      end
      PH_TRAIN: begin
        if (test_nz)       nxt = PH_TEST;
      end
      default: nxt = PH_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dfr_seq_counter.sv
// ============================================================================
//  Module      : dfr_seq_counter
//  Description : Wrapping up-counter with synchronous clear and a last-item
//                flag (value == limit-1).
//  Ports       : S_AXI_ACLK, Local_Reset (async, active-high)
//                clr    - clear to 0 (wins over inc)
//                inc    - increment by one, modulo 2^WIDTH
//                limit  - item count; is_last compares against limit-1
//                value  - current count
//                is_last- value equals limit-1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfr_seq_counter #(
  parameter int WIDTH = 32
) (
  input  logic             S_AXI_ACLK,
  input  logic             Local_Reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value,
  output logic             is_last
);

  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] value_q;

  always_comb begin
    value_d = value_q;
    if (clr)      value_d = '0;
    else if (inc) value_d = value_q + WIDTH'(1);
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) value_q <= '0;
    else             value_q <= value_d;
  end

  assign value   = value_q;
  // limit==0 wraps to all-ones here; callers never ask for is_last then.
  assign is_last = (value_q == (limit - WIDTH'(1)));

endmodule

`default_nettype wire

// File: rtl/dfr_phase_sequencer.sv
// ============================================================================
//  Module      : dfr_phase_sequencer
//  Description : Runs one DFR experiment (INIT, TRAIN, TEST). Each phase
//                fetches its samples over a req/ack port and holds each
//                sample for a fixed number of reservoir steps issued over a
//                valid/ready handshake.
//  Ports       : S_AXI_ACLK, Local_Reset (async, active-high)
//                start, abort            - control from the AXI block
//                num_*                   - counts, latched on start
//                sample_req/addr/ack     - sample fetch port
//                step_valid/ready        - reservoir step handshake
//                capture_en              - step qualifier, TRAIN only
//                phase, step_idx         - progress indicators
//                busy, done              - status to the AXI block
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfr_phase_sequencer #(
  parameter int CNT_W = dfr_pkg::CNT_W
) (
  input  logic             S_AXI_ACLK,
  input  logic             Local_Reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_init_samples,
  input  logic [CNT_W-1:0] num_train_samples,
  input  logic [CNT_W-1:0] num_test_samples,
  input  logic [CNT_W-1:0] num_steps_per_sample,
  output logic             sample_req,
  output logic [CNT_W-1:0] sample_addr,
  input  logic             sample_ack,
  output logic             step_valid,
  input  logic             step_ready,
  output logic             capture_en,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] step_idx,
  output logic             busy,
  output logic             done
);

  import dfr_pkg::*;

  seq_state_t       state_d, state_q;
  phase_t           phase_d, phase_q;
  logic [CNT_W-1:0] init_sh_d, init_sh_q;
  logic [CNT_W-1:0] train_sh_d, train_sh_q;
  logic [CNT_W-1:0] test_sh_d, test_sh_q;
  logic [CNT_W-1:0] steps_sh_d, steps_sh_q;
  // Global address of sample 0 of the current phase.
  logic [CNT_W-1:0] base_d, base_q;

  logic             samp_clr, samp_inc, samp_last;
  logic             step_clr, step_inc, step_last;
  logic             sample_done;
  logic [CNT_W-1:0] samp_limit, samp_value, step_value;
  phase_t           sel_phase;

  dfr_seq_counter #(.WIDTH(CNT_W)) u_sample_cnt (
    .S_AXI_ACLK (S_AXI_ACLK),
    .Local_Reset(Local_Reset),
    .clr        (samp_clr),
    .inc        (samp_inc),
    .limit      (samp_limit),
    .value      (samp_value),
    .is_last    (samp_last)
  );

  dfr_seq_counter #(.WIDTH(CNT_W)) u_step_cnt (
    .S_AXI_ACLK (S_AXI_ACLK),
    .Local_Reset(Local_Reset),
    .clr        (step_clr),
    .inc        (step_inc),
    .limit      (steps_sh_q),
    .value      (step_value),
    .is_last    (step_last)
  );

  assign sel_phase = next_phase(phase_q, (init_sh_q != '0),
                                (train_sh_q != '0), (test_sh_q != '0));

  always_comb begin
    samp_limit = '0;
    case (phase_q)
      PH_INIT:  samp_limit = init_sh_q;
      PH_TRAIN: samp_limit = train_sh_q;
      PH_TEST:  samp_limit = test_sh_q;
      default:  samp_limit = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    base_d      = base_q;
    init_sh_d   = init_sh_q;
    train_sh_d  = train_sh_q;
    test_sh_d   = test_sh_q;
    steps_sh_d  = steps_sh_q;
    samp_clr    = 1'b0;
    samp_inc    = 1'b0;
    step_clr    = 1'b0;
    step_inc    = 1'b0;
    sample_done = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            init_sh_d  = num_init_samples;
            train_sh_d = num_train_samples;
            test_sh_d  = num_test_samples;
            steps_sh_d = num_steps_per_sample;
            phase_d    = PH_IDLE;
            base_d     = '0;
            samp_clr   = 1'b1;
            step_clr   = 1'b1;
            state_d    = SEL_PHASE;
          end
        end
        SEL_PHASE: begin
          if (sel_phase == PH_IDLE) begin
            state_d = DONE;
          end else begin
            phase_d  = sel_phase;
            samp_clr = 1'b1;
            state_d  = FETCH;
          end
        end
        FETCH: begin
          if (sample_ack) begin
            step_clr = 1'b1;
            if (steps_sh_q == '0) sample_done = 1'b1;
            else                  state_d     = STEP;
          end
        end
        STEP: begin
          if (step_ready) begin
            step_inc = 1'b1;
            if (step_last) sample_done = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      // Closing a phase folds its sample count into the base and clears the
      // sample counter, so sample_addr stays contiguous across phases.
      if (sample_done) begin
        if (samp_last) begin
          samp_clr = 1'b1;
          base_d   = base_q + samp_limit;
          state_d  = SEL_PHASE;
        end else begin
          samp_inc = 1'b1;
          state_d  = FETCH;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      state_q    <= IDLE;
      phase_q    <= PH_IDLE;
      base_q     <= '0;
      init_sh_q  <= '0;
      train_sh_q <= '0;
      test_sh_q  <= '0;
      steps_sh_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      base_q     <= base_d;
      init_sh_q  <= init_sh_d;
      train_sh_q <= train_sh_d;
      test_sh_q  <= test_sh_d;
      steps_sh_q <= steps_sh_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign sample_req  = (state_q == FETCH);
  assign step_valid  = (state_q == STEP);
  assign capture_en  = step_valid && (phase_q == PH_TRAIN);
  assign sample_addr = base_q + samp_value;
  assign step_idx    = step_value;

  // In SEL_PHASE the upcoming phase is shown, so the phase output is valid
  // from the first busy cycle and a skipped phase never appears.
  always_comb begin
    phase = phase_q;
    if (state_q == IDLE)
      phase = PH_IDLE;
    else if ((state_q == SEL_PHASE) && (sel_phase != PH_IDLE))
      phase = sel_phase;
  end

endmodule

`default_nettype wire
